// File: rtl/fb_bram_arbiter_if.sv
// Bus bundle for the framebuffer BRAM arbiter: display read port, host write
// port, fill control/status and the shared BRAM port.
interface fb_bram_arbiter_if;
    logic        disp_req;
    logic [31:0] disp_addr;
    logic [31:0] disp_rdata;
    logic        disp_rvalid;
    logic        host_wvalid;
    logic        host_wready;
    logic [31:0] host_waddr;
    logic [31:0] host_wdata;
    logic        fill_start;
    logic [31:0] fill_color;
    logic        fill_busy;
    logic        fill_done;
    logic        wr_drop;
    logic [31:0] bram_addr;
    logic [31:0] bram_din;
    logic [31:0] bram_dout;
    logic        bram_en;
    logic [3:0]  bram_we;

    // Arbiter side
    modport slave (
        input  disp_req, disp_addr, host_wvalid, host_waddr, host_wdata,
               fill_start, fill_color, bram_dout,
        output disp_rdata, disp_rvalid, host_wready, fill_busy, fill_done,
               wr_drop, bram_addr, bram_din, bram_en, bram_we
    );

    // Clients and BRAM side
    modport master (
        output disp_req, disp_addr, host_wvalid, host_waddr, host_wdata,
               fill_start, fill_color, bram_dout,
        input  disp_rdata, disp_rvalid, host_wready, fill_busy, fill_done,
               wr_drop, bram_addr, bram_din, bram_en, bram_we
    );
endinterface

// File: rtl/fb_bram_arbiter.sv
// Single-port framebuffer BRAM arbiter: display reads beat host writes beat
// background fill writes, one registered BRAM access per cycle.
module fb_bram_arbiter #(
    parameter int unsigned H_RES    = 256,
    parameter int unsigned V_RES    = 144,
    parameter int unsigned FB_WORDS = H_RES * V_RES
) (
    input  logic              clk,
    input  logic              reset,
    fb_bram_arbiter_if.slave  bus
);
    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_FILL    = 2'd1;
    localparam logic [1:0]  S_DONE    = 2'd2;
    localparam logic [31:0] FB_BYTES  = 32'(FB_WORDS * 4);
    localparam logic [15:0] LAST_WORD = 16'(FB_WORDS - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] color_q, color_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic        en_q, en_d;
    logic [3:0]  we_q, we_d;
    logic        drop_q, drop_d;
    logic        rd_p1_q, rd_p2_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic        host_gnt, host_ok, fill_gnt;

    always_comb begin
        host_gnt = !bus.disp_req && bus.host_wvalid;
        host_ok  = (bus.host_waddr[1:0] == 2'b00) && (bus.host_waddr < FB_BYTES);
        fill_gnt = !bus.disp_req && !bus.host_wvalid && (state_q == S_FILL);

        addr_d  = addr_q;
        din_d   = din_q;
        en_d    = 1'b0;
        we_d    = 4'h0;
        drop_d  = drop_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;

        if (bus.disp_req) begin
            addr_d = bus.disp_addr;
            en_d   = 1'b1;
        end else if (host_gnt) begin
            // Misaligned or out-of-range writes are swallowed, not forwarded
            if (host_ok) begin
                addr_d = bus.host_waddr;
                din_d  = bus.host_wdata;
                we_d   = 4'hF;
                en_d   = 1'b1;
            end else begin
                drop_d = 1'b1;
            end
        end else if (fill_gnt) begin
            addr_d = {14'd0, cnt_q, 2'b00};
            din_d  = color_q;
            we_d   = 4'hF;
            en_d   = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.fill_start) begin
                    state_d = S_FILL;
                    cnt_d   = '0;
                    color_d = bus.fill_color;
                end
            end
            S_FILL: begin
                if (fill_gnt) begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == LAST_WORD) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            color_q  <= '0;
            addr_q   <= '0;
            din_q    <= '0;
            en_q     <= 1'b0;
            we_q     <= '0;
            drop_q   <= 1'b0;
            rd_p1_q  <= 1'b0;
            rd_p2_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            color_q  <= color_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            en_q     <= en_d;
            we_q     <= we_d;
            drop_q   <= drop_d;
            // Read issued on the BRAM port in N+1, data returns in N+2
            rd_p1_q  <= bus.disp_req;
            rd_p2_q  <= rd_p1_q;
            rvalid_q <= rd_p2_q;
            if (rd_p2_q) rdata_q <= bus.bram_dout;
        end
    end

    assign bus.host_wready = !bus.disp_req && reset;
    assign bus.fill_busy   = (state_q != S_IDLE);
    assign bus.fill_done   = (state_q == S_DONE);
    assign bus.wr_drop     = drop_q;
    assign bus.bram_addr   = addr_q;
    assign bus.bram_din    = din_q;
    assign bus.bram_en     = en_q;
    assign bus.bram_we     = we_q;
    assign bus.disp_rdata  = rdata_q;
    assign bus.disp_rvalid = rvalid_q;
endmodule

// File: doc/fb_bram_arbiter.md
FB_BRAM_ARBITER -- requirements
Module: fb_bram_arbiter

Interface
REQ-001 Parameter H_RES, 256, framebuffer width in pixels.
REQ-002 Parameter V_RES, 144, framebuffer height in pixels.
REQ-003 Parameter FB_WORDS, H_RES*V_RES, framebuffer depth in 32-bit words; byte address = word index * 4.
REQ-004 Port clk  in  1  sole clock; all logic rising-edge.
REQ-005 Port reset  in  1  asynchronous, active-low reset.
REQ-006 Port disp_req  in  1  display read request, one word per asserted cycle.
REQ-007 Port disp_addr  in  32  display byte address, sampled with disp_req.
REQ-008 Port disp_rdata  out  32  display read data.
REQ-009 Port disp_rvalid  out  1  disp_rdata valid, one pulse per granted request.
REQ-010 Port host_wvalid  in  1  host write request.
REQ-011 Port host_wready  out  1  host write accepted this cycle when high with host_wvalid.
REQ-012 Port host_waddr  in  32  host byte address.
REQ-013 Port host_wdata  in  32  host write data.
REQ-014 Port fill_start  in  1  single-cycle pulse starting a framebuffer fill.
REQ-015 Port fill_color  in  32  fill word, sampled on accepted fill_start.
REQ-016 Port fill_busy  out  1  fill in progress.
REQ-017 Port fill_done  out  1  one-cycle pulse at fill completion.
REQ-018 Port wr_drop  out  1  sticky flag: an accepted host write was discarded.
REQ-019 Port bram_addr  out  32  BRAM byte address.
REQ-020 Port bram_din  out  32  BRAM write data.
REQ-021 Port bram_dout  in  32  BRAM read data, valid one cycle after the read cycle.
REQ-022 Port bram_en  out  1  BRAM enable.
REQ-023 Port bram_we  out  4  BRAM byte write enables.

Function
REQ-024 Fixed priority each cycle: display read > host write > fill write; one grant at most per cycle.
REQ-025 host_wready SHALL be combinational: high exactly when disp_req is low and reset is deasserted.
REQ-026 bram_addr/bram_din/bram_en/bram_we SHALL be registered: the grant decided in cycle N drives them in cycle N+1; no grant -> bram_en=0, bram_we=0, addr/din hold.
REQ-027 Display grant: bram_addr=disp_addr, bram_we=4'h0, bram_en=1; disp_addr passes unchanged, no range check.
REQ-028 Display latency: request in cycle N -> bram_dout sampled at end of N+2 into disp_rdata, disp_rvalid high in N+3; back-to-back requests yield back-to-back rvalid in order.
REQ-029 Host grant: if host_waddr[1:0]==0 and host_waddr < FB_WORDS*4, drive addr/din, bram_we=4'hF, bram_en=1; else drop the write (no BRAM access) and set wr_drop.
REQ-030 Fill FSM states IDLE, FILL, DONE; IDLE->FILL on fill_start, clearing 16-bit word counter cnt and latching fill_color.
REQ-031 FILL: in each cycle with neither disp_req nor host_wvalid, write latched color to byte address cnt*4 with bram_we=4'hF, then cnt+1.
REQ-032 FILL->DONE after the write of cnt==FB_WORDS-1; DONE lasts one cycle with fill_done=1, then IDLE.
REQ-033 fill_busy high in FILL and DONE; fill_start while not IDLE SHALL be ignored (no restart, color unchanged).
REQ-034 Host writes during FILL may be overwritten by later fill writes; no ordering guarantee beyond per-cycle priority.
REQ-035 Continuous disp_req starves host and fill indefinitely; no timeout, no lost state.
REQ-036 Counter arithmetic unsigned; cnt*4 zero-extended to 32 bits.

Reset
REQ-037 reset low SHALL asynchronously clear: FSM to IDLE, cnt=0, latched color=0, disp_rdata=0, disp_rvalid=0 and its pipeline, fill_busy=0, fill_done=0, wr_drop=0, bram_addr=0, bram_din=0, bram_en=0, bram_we=0.
REQ-038 Reset during FILL aborts the fill with no fill_done pulse; in-flight display reads produce no rvalid.
REQ-039 wr_drop clears only on reset.

Verification
REQ-040 disp_req 1 cycle, disp_addr=0x40, bram_dout=0xDEADBEEF in N+2 -> bram_en=1,we=0,addr=0x40 in N+1; disp_rvalid=1, disp_rdata=0xDEADBEEF in N+3.
REQ-041 host_wvalid with disp_req high 3 cycles -> host_wready=0 for 3 cycles; write 0x11223344 to 0x100 appears with we=4'hF the cycle after disp_req falls.
REQ-042 fill_start, fill_color=0x00FF00FF, no other traffic -> exactly 36864 writes, addresses 0x0..0x23FFC stepping 4, fill_done one cycle after last write, fill_busy low afterwards.
REQ-043 Host write to 0x24000 and to 0x102 -> no bram_en, wr_drop=1 and stays 1.
REQ-044 fill_start mid-fill with new color -> ignored; all 36864 words carry original color.
REQ-045 reset asserted after 100 fill writes -> all outputs to reset values immediately, no fill_done; fresh fill_start restarts from address 0.
